// File: rtl/flag_reg_stack.sv
// Working register with bitwise flag operations and a small LIFO of saved values.
// Stack underflow/overflow raises a sticky ERR; all outputs come straight from registered state.
module flag_reg_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [2:0]                 OP,
  input  logic [WIDTH-1:0]           DATA_in,
  input  logic                       ERR_clr,
  output logic [WIDTH-1:0]           Q,
  output logic [WIDTH-1:0]           TOP,
  output logic [$clog2(DEPTH+1)-1:0] LEVEL,
  output logic                       FULL,
  output logic                       EMPTY,
  output logic                       ERR
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ONE = LW'(1);

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_SET  = 3'd2,
    OP_CLR  = 3'd3,
    OP_TOG  = 3'd4,
    OP_PUSH = 3'd5,
    OP_POP  = 3'd6,
    OP_SWAP = 3'd7
  } op_e;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_stack [DEPTH];
  logic [LW-1:0]    r_level;
  logic             r_err;

  op_e              w_op;
  logic             w_full;
  logic             w_empty;
  logic [IW-1:0]    w_top_idx;
  logic [IW-1:0]    w_push_idx;
  logic [WIDTH-1:0] w_top;

  assign w_op    = op_e'(OP);
  assign w_full  = (r_level == LVL_MAX);
  assign w_empty = (r_level == '0);

  // Index values are only meaningful when the matching guard (not empty / not full) holds.
  assign w_top_idx  = w_empty ? '0 : IW'(r_level - LVL_ONE);
  assign w_push_idx = w_full  ? '0 : IW'(r_level);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_top = '0;
    if (!w_empty) w_top = r_stack[w_top_idx];
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values;
  // that is what lets SWAP exchange Q and the top entry in a single edge.
  // NOTE: the stack array is reset along with the other state because reset must clear every entry.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_q     <= '0;
      r_level <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_stack[i] <= '0;
    end else begin
      if (ERR_clr) r_err <= 1'b0;

      case (w_op)
        OP_NOP:  ;
        OP_LOAD: r_q <= DATA_in;
        OP_SET:  r_q <= r_q | DATA_in;
        OP_CLR:  r_q <= r_q & ~DATA_in;
        OP_TOG:  r_q <= r_q ^ DATA_in;
        OP_PUSH: begin
          if (w_full) begin
            r_err <= 1'b1;
          end else begin
            r_stack[w_push_idx] <= r_q;
            r_level             <= r_level + LVL_ONE;
          end
        end
        OP_POP: begin
          if (w_empty) begin
            r_err <= 1'b1;
          end else begin
            r_q     <= r_stack[w_top_idx];
            r_level <= r_level - LVL_ONE;
          end
        end
        OP_SWAP: begin
          if (w_empty) begin
            r_err <= 1'b1;
          end else begin
            r_q                <= r_stack[w_top_idx];
            r_stack[w_top_idx] <= r_q;
          end
        end
        default: ;
      endcase
      // Error assignments above come after the ERR_clr clear, so a same-edge error wins.
    end
  end

  assign Q     = r_q;
  assign TOP   = w_top;
  assign LEVEL = r_level;
  assign FULL  = w_full;
  assign EMPTY = w_empty;
  assign ERR   = r_err;

endmodule

// File: tb/tb_flag_reg_stack.sv
// Self-checking bench for flag_reg_stack: directed vector table, async-reset sequence,
// and random operations compared against a queue-based reference model.
module tb_flag_reg_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  localparam logic [2:0] NOP  = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] SET  = 3'd2;
  localparam logic [2:0] CLR  = 3'd3;
  localparam logic [2:0] TOG  = 3'd4;
  localparam logic [2:0] PUSH = 3'd5;
  localparam logic [2:0] POP  = 3'd6;
  localparam logic [2:0] SWAP = 3'd7;

  logic             CLK = 1'b0;
  logic             RESET;
  logic [2:0]       OP;
  logic [WIDTH-1:0] DATA_in;
  logic             ERR_clr;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] TOP;
  logic [LW-1:0]    LEVEL;
  logic             FULL;
  logic             EMPTY;
  logic             ERR;

  flag_reg_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET), .OP(OP), .DATA_in(DATA_in), .ERR_clr(ERR_clr),
    .Q(Q), .TOP(TOP), .LEVEL(LEVEL), .FULL(FULL), .EMPTY(EMPTY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] data;
    logic             clr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] top;
    logic [LW-1:0]    lvl;
    logic             err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [2:0] op, logic [WIDTH-1:0] data, logic clr,
                              logic [WIDTH-1:0] q, logic [WIDTH-1:0] top,
                              logic [LW-1:0] lvl, logic err);
    vec_t v;
    v.op = op; v.data = data; v.clr = clr;
    v.q = q; v.top = top; v.lvl = lvl; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [WIDTH-1:0] q,
                           input logic [WIDTH-1:0] top, input logic [LW-1:0] lvl,
                           input logic err);
    check({tag, " Q"},     32'(Q),     32'(q));
    check({tag, " TOP"},   32'(TOP),   32'(top));
    check({tag, " LEVEL"}, 32'(LEVEL), 32'(lvl));
    check({tag, " FULL"},  32'(FULL),  32'(lvl == LW'(DEPTH)));
    check({tag, " EMPTY"}, 32'(EMPTY), 32'(lvl == '0));
    check({tag, " ERR"},   32'(ERR),   32'(err));
  endtask

  // Drive away from the active edge, then sample 1 time unit after it.
  task automatic step(input logic [2:0] op, input logic [WIDTH-1:0] d, input logic clr);
    @(negedge CLK);
    OP = op; DATA_in = d; ERR_clr = clr;
    @(posedge CLK);
    #1;
  endtask

  // Reference model state
  logic [WIDTH-1:0] m_q;
  logic             m_err;
  logic [WIDTH-1:0] m_stk[$];

  task automatic model_apply(input logic [2:0] op, input logic [WIDTH-1:0] d, input logic clr);
    logic             ev;
    logic [WIDTH-1:0] t;
    ev = 1'b0;
    case (op)
      LOAD: m_q = d;
      SET:  m_q = m_q | d;
      CLR:  m_q = m_q & ~d;
      TOG:  m_q = m_q ^ d;
      PUSH: if (m_stk.size() == DEPTH) ev = 1'b1; else m_stk.push_back(m_q);
      POP:  if (m_stk.size() == 0) ev = 1'b1; else m_q = m_stk.pop_back();
      SWAP: begin
        if (m_stk.size() == 0) ev = 1'b1;
        else begin
          t = m_stk[$];
          m_stk[$] = m_q;
          m_q = t;
        end
      end
      default: ;
    endcase
    if (ev) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
  endtask

  initial begin
    RESET = 1'b0; OP = NOP; DATA_in = '0; ERR_clr = 1'b0;
    #12;
    check_all("reset", 8'h00, 8'h00, 3'd0, 1'b0);
    @(negedge CLK);
    RESET = 1'b1;

    // Flag operations
    vecs.push_back(mk(LOAD, 8'hA5, 0, 8'hA5, 8'h00, 3'd0, 0));
    vecs.push_back(mk(SET,  8'h0F, 0, 8'hAF, 8'h00, 3'd0, 0));
    vecs.push_back(mk(CLR,  8'h81, 0, 8'h2E, 8'h00, 3'd0, 0));
    vecs.push_back(mk(TOG,  8'hFF, 0, 8'hD1, 8'h00, 3'd0, 0));
    vecs.push_back(mk(NOP,  8'hFF, 0, 8'hD1, 8'h00, 3'd0, 0));
    // Push / pop ordering
    vecs.push_back(mk(LOAD, 8'h11, 0, 8'h11, 8'h00, 3'd0, 0));
    vecs.push_back(mk(PUSH, 8'h00, 0, 8'h11, 8'h11, 3'd1, 0));
    vecs.push_back(mk(LOAD, 8'h22, 0, 8'h22, 8'h11, 3'd1, 0));
    vecs.push_back(mk(PUSH, 8'h00, 0, 8'h22, 8'h22, 3'd2, 0));
    vecs.push_back(mk(LOAD, 8'h33, 0, 8'h33, 8'h22, 3'd2, 0));
    vecs.push_back(mk(POP,  8'h00, 0, 8'h22, 8'h11, 3'd1, 0));
    vecs.push_back(mk(POP,  8'h00, 0, 8'h11, 8'h00, 3'd0, 0));
    // Overflow
    vecs.push_back(mk(LOAD, 8'h5A, 0, 8'h5A, 8'h00, 3'd0, 0));
    vecs.push_back(mk(PUSH, 8'h00, 0, 8'h5A, 8'h5A, 3'd1, 0));
    vecs.push_back(mk(PUSH, 8'h00, 0, 8'h5A, 8'h5A, 3'd2, 0));
    vecs.push_back(mk(PUSH, 8'h00, 0, 8'h5A, 8'h5A, 3'd3, 0));
    vecs.push_back(mk(PUSH, 8'h00, 0, 8'h5A, 8'h5A, 3'd4, 0));
    vecs.push_back(mk(PUSH, 8'h00, 0, 8'h5A, 8'h5A, 3'd4, 1));
    vecs.push_back(mk(LOAD, 8'h77, 0, 8'h77, 8'h5A, 3'd4, 1));
    vecs.push_back(mk(POP,  8'h00, 0, 8'h5A, 8'h5A, 3'd3, 1));
    vecs.push_back(mk(POP,  8'h00, 0, 8'h5A, 8'h5A, 3'd2, 1));
    vecs.push_back(mk(POP,  8'h00, 0, 8'h5A, 8'h5A, 3'd1, 1));
    vecs.push_back(mk(POP,  8'h00, 0, 8'h5A, 8'h00, 3'd0, 1));
    vecs.push_back(mk(NOP,  8'h00, 1, 8'h5A, 8'h00, 3'd0, 0));
    // Underflow and set-wins-over-clear
    vecs.push_back(mk(POP,  8'h00, 0, 8'h5A, 8'h00, 3'd0, 1));
    vecs.push_back(mk(SWAP, 8'h00, 1, 8'h5A, 8'h00, 3'd0, 1));
    vecs.push_back(mk(NOP,  8'h00, 0, 8'h5A, 8'h00, 3'd0, 1));
    vecs.push_back(mk(NOP,  8'h00, 1, 8'h5A, 8'h00, 3'd0, 0));
    // Swap
    vecs.push_back(mk(LOAD, 8'h3C, 0, 8'h3C, 8'h00, 3'd0, 0));
    vecs.push_back(mk(PUSH, 8'h00, 0, 8'h3C, 8'h3C, 3'd1, 0));
    vecs.push_back(mk(LOAD, 8'hC3, 0, 8'hC3, 8'h3C, 3'd1, 0));
    vecs.push_back(mk(SWAP, 8'h00, 0, 8'h3C, 8'hC3, 3'd1, 0));
    vecs.push_back(mk(SET,  8'h01, 0, 8'h3D, 8'hC3, 3'd1, 0));

    foreach (vecs[i]) begin
      step(vecs[i].op, vecs[i].data, vecs[i].clr);
      check_all($sformatf("vec%0d", i), vecs[i].q, vecs[i].top, vecs[i].lvl, vecs[i].err);
    end

    // Asynchronous reset mid-cycle with LEVEL=3 and ERR=1
    step(PUSH, 8'h00, 0);
    step(PUSH, 8'h00, 0);
    step(PUSH, 8'h00, 0);
    step(PUSH, 8'h00, 0);
    step(POP,  8'h00, 0);
    check_all("pre_rst", 8'h3D, 8'h3D, 3'd3, 1'b1);
    @(negedge CLK);
    OP = PUSH;
    #2;
    RESET = 1'b0;
    #1;
    check_all("async_rst", 8'h00, 8'h00, 3'd0, 1'b0);
    @(posedge CLK);
    #1;
    check_all("rst_held", 8'h00, 8'h00, 3'd0, 1'b0);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    check_all("rst_release_push", 8'h00, 8'h00, 3'd1, 1'b0);

    // Random operations against the reference model
    @(negedge CLK);
    RESET = 1'b0;
    OP = NOP;
    #2;
    RESET = 1'b1;
    m_q = '0; m_err = 1'b0; m_stk.delete();
    for (int n = 0; n < 600; n++) begin
      logic [2:0]       op;
      logic [WIDTH-1:0] d;
      logic             clr;
      op  = 3'($urandom_range(0, 7));
      d   = WIDTH'($urandom);
      clr = ($urandom_range(0, 7) == 0);
      step(op, d, clr);
      model_apply(op, d, clr);
      check_all($sformatf("rnd%0d", n), m_q,
                (m_stk.size() == 0) ? '0 : m_stk[$],
                LW'(m_stk.size()), m_err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
